// File: rtl/proc_param.sv
// Parametrised multi-cycle processor: one instruction at a time over a shared
// bus, with N-bit datapath, 2^RSEL registers, a zero flag and Run-gated fetch.
module proc_param #(
  parameter int N    = 16,
  parameter int RSEL = 3
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [N-1:0] DIN,
  input  logic         Run,
  output logic         Done,
  output logic [N-1:0] BusWires,
  output logic         Zero
);
  localparam int IW = 2*RSEL + 3;
  localparam int NR = 1 << RSEL;

  typedef enum logic [1:0] {T0, T1, T2, T3} step_t;
  typedef enum logic [2:0] {
    OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_MVNZ, OP_AND, OP_NOP0, OP_NOP1
  } op_t;

  step_t            step, step_next;
  logic [IW-1:0]    ir;
  logic [N-1:0]     a, g, alu;
  logic [N-1:0]     regs [NR];
  op_t              op;
  logic [RSEL-1:0]  rx, ry, reg_idx;
  logic             is_alu;
  logic             ld_ir, ld_a, ld_g, wr_en;
  logic             sel_din, sel_g, sel_reg;

  assign op     = op_t'(ir[IW-1:2*RSEL]);
  assign rx     = ir[2*RSEL-1:RSEL];
  assign ry     = ir[RSEL-1:0];
  assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);

  always_ff @(posedge Clock) begin
    if (!Resetn) step <= T0;
    else         step <= step_next;
  end

  always_comb begin
    step_next = step;
    case (step)
      T0: if (Run) step_next = T1;
      T1: step_next = is_alu ? T2 : T0;
      T2: step_next = T3;
      T3: step_next = T0;
      default: step_next = T0;
    endcase
  end

  always_comb begin
    Done    = 1'b0;
    ld_ir   = 1'b0;
    ld_a    = 1'b0;
    ld_g    = 1'b0;
    wr_en   = 1'b0;
    sel_din = 1'b0;
    sel_g   = 1'b0;
    sel_reg = 1'b0;
    reg_idx = ry;
    case (step)
      T0: ld_ir = Run;
      T1: begin
        case (op)
          OP_MV: begin
            sel_reg = 1'b1;
            wr_en   = 1'b1;
            Done    = 1'b1;
          end
          OP_MVI: begin
            sel_din = 1'b1;
            wr_en   = 1'b1;
            Done    = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            sel_reg = 1'b1;
            reg_idx = rx;
            ld_a    = 1'b1;
          end
          OP_MVNZ: begin
            sel_reg = !Zero;
            wr_en   = !Zero;
            Done    = 1'b1;
          end
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        sel_reg = 1'b1;
        ld_g    = 1'b1;
      end
      T3: begin
        sel_g = 1'b1;
        wr_en = 1'b1;
        Done  = 1'b1;
      end
      default: ;
    endcase
  end

  // Undriven bus reads as zero rather than floating.
  always_comb begin
    BusWires = '0;
    if (sel_din)      BusWires = DIN;
    else if (sel_g)   BusWires = g;
    else if (sel_reg) BusWires = regs[reg_idx];
  end

  always_comb begin
    case (op)
      OP_SUB:  alu = a + ~BusWires + {{(N-1){1'b0}}, 1'b1};
      OP_AND:  alu = a & BusWires;
      default: alu = a + BusWires;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      ir   <= '0;
      a    <= '0;
      g    <= '0;
      Zero <= 1'b1;
      for (int unsigned k = 0; k < NR; k++) regs[k] <= '0;
    end else begin
      if (ld_ir) ir <= DIN[IW-1:0];
      if (ld_a)  a  <= BusWires;
      if (ld_g) begin
        g    <= alu;
        Zero <= (alu == '0);
      end
      if (wr_en) regs[rx] <= BusWires;
    end
  end
endmodule

// File: tb/tb_proc_param.sv
// Directed bench for proc_param: an instruction-level model predicts Done, bus and
// Zero for every cycle of the 16-bit core; a short literal sequence covers N=8.
module tb_proc_param;
  logic        Clock;
  logic        Resetn, Run, Done, Zero;
  logic [15:0] DIN, BusWires;
  logic        Resetn8, Run8, Done8, Zero8;
  logic [7:0]  DIN8, Bus8;

  proc_param #(.N(16), .RSEL(3)) dut (
    .Clock(Clock), .Resetn(Resetn), .DIN(DIN), .Run(Run),
    .Done(Done), .BusWires(BusWires), .Zero(Zero)
  );

  proc_param #(.N(8), .RSEL(2)) dut8 (
    .Clock(Clock), .Resetn(Resetn8), .DIN(DIN8), .Run(Run8),
    .Done(Done8), .BusWires(Bus8), .Zero(Zero8)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        done;
    logic [15:0] bus;
    logic        zero;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] mreg [8];
  logic        mzero;
  int          n_checks = 0;
  int          n_fail   = 0;
  localparam logic [15:0] JUNK = 16'hA5C3;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("done", {15'd0, Done}, {15'd0, e.done});
      chk("bus", BusWires, e.bus);
      chk("zero", {15'd0, Zero}, {15'd0, e.zero});
    end
  end

  task automatic step(input logic rn, input logic run, input logic [15:0] din,
                      input logic ed, input logic [15:0] eb);
    @(posedge Clock); #1;
    Resetn = rn; Run = run; DIN = din;
    expq.push_back('{ed, eb, mzero});
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) mreg[k] = 16'h0;
    mzero = 1'b1;
  endtask

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
    return {7'h55, op, x, y};
  endfunction

  task automatic issue(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                       input logic [15:0] imm);
    logic [15:0] av, bv, r;
    step(1'b1, 1'b1, enc(op, x, y), 1'b0, 16'h0);
    case (op)
      3'd0: begin step(1'b1, 1'b1, JUNK, 1'b1, mreg[y]); mreg[x] = mreg[y]; end
      3'd1: begin step(1'b1, 1'b1, imm, 1'b1, imm); mreg[x] = imm; end
      3'd2, 3'd3, 3'd5: begin
        av = mreg[x];
        step(1'b1, 1'b1, JUNK, 1'b0, av);
        bv = mreg[y];
        step(1'b1, 1'b1, JUNK, 1'b0, bv);
        if (op == 3'd2)      r = av + bv;
        else if (op == 3'd3) r = av - bv;
        else                 r = av & bv;
        mzero = (r == 16'h0);
        step(1'b1, 1'b1, JUNK, 1'b1, r);
        mreg[x] = r;
      end
      3'd4: begin
        step(1'b1, 1'b1, JUNK, 1'b1, mzero ? 16'h0 : mreg[y]);
        if (!mzero) mreg[x] = mreg[y];
      end
      default: step(1'b1, 1'b1, JUNK, 1'b1, 16'h0);
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, JUNK, 1'b0, 16'h0);
  endtask

  task automatic step8(input string name, input logic rn, input logic run, input logic [7:0] din,
                       input logic ed, input logic [7:0] eb, input logic ez);
    @(posedge Clock); #1;
    Resetn8 = rn; Run8 = run; DIN8 = din;
    @(negedge Clock);
    chk({name, "_done"}, {15'd0, Done8}, {15'd0, ed});
    chk({name, "_bus"}, {8'd0, Bus8}, {8'd0, eb});
    chk({name, "_zero"}, {15'd0, Zero8}, {15'd0, ez});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Resetn = 1'b0; Run = 1'b0; DIN = JUNK;
    Resetn8 = 1'b0; Run8 = 1'b0; DIN8 = 8'h00;
    model_reset();
    @(posedge Clock); #1;
    step(1'b0, 1'b1, JUNK, 1'b0, 16'h0);
    idle(5);

    issue(3'd1, 3'd0, 3'd0, 16'd5);
    issue(3'd0, 3'd1, 3'd0, 16'd0);
    chk("pin_mv_r1", mreg[1], 16'd5);

    issue(3'd4, 3'd4, 3'd0, 16'd0);
    chk("pin_mvnz_hold", mreg[4], 16'd0);

    issue(3'd2, 3'd0, 3'd1, 16'd0);
    chk("pin_add_r0", mreg[0], 16'd10);
    chk("pin_add_zero", {15'd0, mzero}, 16'd0);

    issue(3'd4, 3'd4, 3'd0, 16'd0);
    chk("pin_mvnz_copy", mreg[4], 16'd10);
    idle(2);

    issue(3'd1, 3'd2, 3'd0, 16'd0);
    issue(3'd1, 3'd3, 3'd0, 16'd1);
    issue(3'd3, 3'd2, 3'd3, 16'd0);
    chk("pin_sub_wrap", mreg[2], 16'hFFFF);
    issue(3'd3, 3'd3, 3'd3, 16'd0);
    chk("pin_sub_self", mreg[3], 16'd0);
    chk("pin_sub_zero", {15'd0, mzero}, 16'd1);

    issue(3'd1, 3'd5, 3'd0, 16'hF0F0);
    issue(3'd1, 3'd6, 3'd0, 16'h0FF0);
    issue(3'd5, 3'd5, 3'd6, 16'd0);
    chk("pin_and", mreg[5], 16'h00F0);

    issue(3'd1, 3'd7, 3'd0, 16'h8001);
    issue(3'd2, 3'd7, 3'd7, 16'd0);
    chk("pin_double", mreg[7], 16'h0002);

    issue(3'd6, 3'd1, 3'd2, 16'd0);
    issue(3'd7, 3'd3, 3'd4, 16'd0);
    idle(1);

    // Abort add R0,R1 by reset during its T2 step.
    step(1'b1, 1'b1, enc(3'd2, 3'd0, 3'd1), 1'b0, 16'h0);
    step(1'b1, 1'b1, JUNK, 1'b0, mreg[0]);
    step(1'b0, 1'b1, JUNK, 1'b0, mreg[1]);
    model_reset();
    idle(2);
    for (int k = 0; k < 8; k++) issue(3'd0, k[2:0], k[2:0], 16'd0);
    chk("pin_reset_r0", mreg[0], 16'd0);
    @(negedge Clock); #1;
    Run = 1'b0;
    chk("queue_drained", expq.size() == 0 ? 16'd1 : 16'd0, 16'd1);

    step8("r8_reset", 1'b0, 1'b1, 8'h2F, 1'b0, 8'h00, 1'b1);
    step8("r8_mvi_t0", 1'b1, 1'b1, 8'h1C, 1'b0, 8'h00, 1'b1);
    step8("r8_mvi_t1", 1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1);
    step8("r8_add_t0", 1'b1, 1'b1, 8'h2F, 1'b0, 8'h00, 1'b1);
    step8("r8_add_t1", 1'b1, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b1);
    step8("r8_add_t2", 1'b1, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b1);
    step8("r8_add_t3", 1'b1, 1'b1, 8'h00, 1'b1, 8'hFE, 1'b0);
    step8("r8_mv_t0", 1'b1, 1'b1, 8'h0F, 1'b0, 8'h00, 1'b0);
    step8("r8_mv_t1", 1'b1, 1'b1, 8'h00, 1'b1, 8'hFE, 1'b0);
    step8("r8_add2_t0", 1'b1, 1'b1, 8'h2F, 1'b0, 8'h00, 1'b0);
    step8("r8_add2_t1", 1'b1, 1'b1, 8'h00, 1'b0, 8'hFE, 1'b0);
    step8("r8_add2_t2", 1'b0, 1'b1, 8'h00, 1'b0, 8'hFE, 1'b0);
    step8("r8_post_rst", 1'b1, 1'b0, 8'h0F, 1'b0, 8'h00, 1'b1);
    step8("r8_rd_t0", 1'b1, 1'b1, 8'h0F, 1'b0, 8'h00, 1'b1);
    step8("r8_rd_t1", 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/proc_param.md
# proc_param

Parametrised successor to the team's 16-bit, 8-register multi-cycle processor. It executes one instruction at a time over a shared data bus. Data width and register count are parameters. Compared with the previous generation, it adds Run-gated instruction fetch, a defined idle bus value, a zero flag, and three new instructions: conditional move (mvnz), bitwise and, and no-op. It sits between the instruction/data source driving DIN and the system bus observed on BusWires.

## Interface
- N, 16, data/bus/register width in bits (≥ 2·RSEL+3)
- RSEL, 3, register-select field width; register file holds 2^RSEL registers R0..R(2^RSEL−1)
- Clock  in  1  system clock, all state updates on rising edge
- Resetn  in  1  reset, synchronous, active-low
- DIN  in  N  instruction word (in T0) or immediate operand (in T1 of mvi)
- Run  in  1  start request, sampled only in T0
- Done  out  1  high during the final step of an instruction (combinational)
- BusWires  out  N  shared data bus value
- Zero  out  1  registered flag, 1 when the last value written into G was 0

## Operation
- Instruction word fields:
  - DIN[2·RSEL+2 : 2·RSEL] is the opcode I.
  - DIN[2·RSEL−1 : RSEL] is X.
  - DIN[RSEL−1 : 0] is Y.
  - Upper DIN bits are ignored.
- Internal state:
  - IR (2·RSEL+3 bits), A (N), G (N), Zero, and the register file.
  - Step counter with states T0..T3.
- Bus drivers are one-hot and at most one is active per cycle: DIN, G, or Rk. When no driver is active, BusWires = 0.
- Opcodes and step actions:
  - 000 mv Rx,Ry: T1 Ry→Rx, Done.
  - 001 mvi Rx,#D: T1 DIN→Rx, Done. The immediate is presented on DIN during T1.
  - 010 add Rx,Ry: T1 Rx→A; T2 Ry on bus, G←A+Bus; T3 G→Rx, Done.
  - 011 sub Rx,Ry: same sequence as add, with G←A−Bus.
  - 100 mvnz Rx,Ry: T1 if Zero=0 then Ry→Rx; Done regardless.
  - 101 and Rx,Ry: same sequence as add, with G←A & Bus.
  - 110, 111 nop: T1 Done, no register write.
- Arithmetic is modulo 2^N. Carry and borrow are discarded. Subtraction is A + ~Bus + 1.
- Zero updates only on cycles where G loads: Zero ← (new G == 0).
- X = Y is legal. For add with X = Y, Rx is doubled.

## Timing
- Reset (Resetn=0 at a rising edge):
  - Step counter → T0.
  - IR, A, G, and all Rk → 0.
  - Zero → 1.
  - Reset overrides any write scheduled in the same cycle.
- Reset mid-instruction aborts it. No partial result is written to Rx on or after the reset edge.
- Reset outputs: Done=0 and BusWires=0 while in T0.
- T0 (idle/fetch):
  - If Run=1, IR←DIN and the next state is T1.
  - If Run=0, the block stays in T0 and IR holds.
- Transitions: T1→T2 and T2→T3 occur only for add/sub/and. Every other opcode returns T1→T0.
- Done is high in the last step: T1 for mv/mvi/mvnz/nop, T3 for add/sub/and. The next edge returns the counter to T0.
- Latency from the Run-sampled edge:
  - mv/mvi/mvnz/nop: 2 cycles to T0.
  - add/sub/and: 4 cycles to T0.
- Back-to-back issue: Run held high in T0 immediately after Done fetches the next instruction with no bubble.
- Run is ignored outside T0. DIN is ignored except in T0 (with Run) and in mvi T1.
- Register writes take effect at the edge ending the step that asserts them. A value written by Done is visible on the bus from the next cycle.

## Test plan
- Reset then idle: hold Resetn=0 for 2 cycles, then Run=0 for 5 cycles. Required: Done=0 throughout, BusWires=0, Zero=1, no state change.
- mvi/mv: issue mvi R0,#5, then mv R1,R0 back-to-back with Run held high. Required: Done in cycles 2 and 4; R1=5, seen on BusWires=5 during the mv T1.
- add: with R0=5 and R1=5, issue add R0,R1. Required: Done only in T3; BusWires=10 in T3; R0=10; Zero=0.
- sub wrap: with R2=0 and R3=1, issue sub R2,R3. Required: R2=0xFFFF (N=16), Zero=0. Then sub R3,R3 gives R3=0 and Zero=1.
- mvnz: with Zero=1, mvnz R4,R0 leaves R4 unchanged, Done in T1. After an add producing nonzero, the same mvnz copies R0 into R4.
- Reset mid-add: assert Resetn=0 during T2 of add R0,R1. Required: next cycle is T0, all registers 0, Done never asserted. Repeat with N=8, RSEL=2 using mvi R3,#0xFF then add R3,R3, which gives R3=0xFE.
